condlogic_hold: RTL and testbench

Parametrised condition unit for the multicycle ARM datapath. It sits between the main FSM decoder and the datapath enables. It holds the NZCV flag register with configurable flag-write grouping and evaluates the instruction condition. It keeps the condition result valid for the whole multicycle instruction, either by per-cycle registering (legacy mode) or by sample-and-hold at decode (hold mode). It also adds a flag shadow register for exception save/restore and optional condition-gated flag writes.

---
 rtl/condlogic_hold_pkg.sv | 28 ++
 rtl/condlogic_hold_cond_eval.sv | 44 ++++
 rtl/condlogic_hold.sv | 87 ++++++++
 tb/tb_condlogic_hold.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/condlogic_hold_pkg.sv
// condlogic_hold_pkg
// Shared constants for the condition unit: ARM condition-code encodings and
// bit positions of the N, Z, C, V flags inside the 4-bit flag vector.
package condlogic_hold_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/condlogic_hold_cond_eval.sv
// cond_eval
// Purely combinational ARM condition decoder.
// Ports:
//   cond   in  4  instruction condition field
//   flags  in  4  {N,Z,C,V}
//   condEx out 1  condition passes
module cond_eval
    import condlogic_hold_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       condEx
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        condEx = 1'b0;
        case (cond)
            COND_EQ: condEx = z;
            COND_NE: condEx = ~z;
            COND_CS: condEx = c;
            COND_CC: condEx = ~c;
            COND_MI: condEx = n;
            COND_PL: condEx = ~n;
            COND_VS: condEx = v;
            COND_VC: condEx = ~v;
            COND_HI: condEx = c & ~z;
            COND_LS: condEx = ~c | z;
            COND_GE: condEx = (n == v);
            COND_LT: condEx = (n != v);
            COND_GT: condEx = ~z & (n == v);
            COND_LE: condEx = z | (n != v);
            COND_AL: condEx = 1'b1;
            default: condEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/condlogic_hold.sv
// condlogic_hold
// Condition unit for the multicycle ARM datapath: NZCV register with grouped
// flag writes, a shadow copy for exception save/restore, and a condition
// result held for the whole multicycle instruction.
// Ports:
//   clk, reset (sync, active-low)
//   Cond, ALUFlags, FlagW[NGROUPS], CondSample, PCS, NextPC, RegW, MemW,
//   SaveFlags, RestoreFlags                              -> inputs
//   PCWrite, RegWrite, MemWrite, Flags[4], CondExHeld    -> outputs
module condlogic_hold
    import condlogic_hold_pkg::*;
#(
    parameter int NGROUPS     = 2,
    parameter int HOLD_MODE   = 1,
    parameter int FLAGW_GATED = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         Cond,
    input  logic [3:0]         ALUFlags,
    input  logic [NGROUPS-1:0] FlagW,
    input  logic               CondSample,
    input  logic               PCS,
    input  logic               NextPC,
    input  logic               RegW,
    input  logic               MemW,
    input  logic               SaveFlags,
    input  logic               RestoreFlags,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic [3:0]         Flags,
    output logic               CondExHeld
);

    if (!(NGROUPS == 1 || NGROUPS == 2 || NGROUPS == 4)) begin : gBadNgroups
        $error("condlogic_hold: NGROUPS must be 1, 2 or 4");
    end

    logic [3:0]         flagsQ;
    logic [3:0]         shadowQ;
    logic               heldQ;
    logic               condEx;
    logic [3:0]         flagsWr;
    logic [NGROUPS-1:0] groupEn;

    cond_eval uCondEval (
        .cond   (Cond),
        .flags  (flagsQ),
        .condEx (condEx)
    );

    // Each group owns a contiguous slice of NZCV; group NGROUPS-1 holds N.
    for (genvar g = 0; g < NGROUPS; g++) begin : gGroup
        localparam int LO = g * 4 / NGROUPS;
        localparam int HI = (g + 1) * 4 / NGROUPS - 1;

        assign groupEn[g]      = FlagW[g] & ((FLAGW_GATED != 0) ? heldQ : 1'b1);
        assign flagsWr[HI:LO]  = groupEn[g] ? ALUFlags[HI:LO] : flagsQ[HI:LO];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            flagsQ  <= 4'b0000;
            shadowQ <= 4'b0000;
            heldQ   <= 1'b0;
        end else begin
            // Restore wins over ALU writes; with Save in the same cycle the
            // two registers swap because both use pre-edge values.
            if (RestoreFlags) flagsQ <= shadowQ;
            else              flagsQ <= flagsWr;

            if (SaveFlags) shadowQ <= flagsQ;

            // condEx is derived from pre-edge flags, so a flag write in the
            // sampling cycle does not affect the captured result.
            if (HOLD_MODE == 0 || CondSample) heldQ <= condEx;
        end
    end

    assign Flags      = flagsQ;
    assign CondExHeld = heldQ;
    assign RegWrite   = RegW & heldQ;
    assign MemWrite   = MemW & heldQ;
    assign PCWrite    = (PCS & heldQ) | NextPC;

endmodule

// File: tb/tb_condlogic_hold.sv
module tb_condlogic_hold;
    import condlogic_hold_pkg::*;

    logic       clk = 1'b0;
    logic       reset;

    // main instance: NGROUPS=2, HOLD_MODE=1, FLAGW_GATED=1
    logic [3:0] Cond, ALUFlags, Flags;
    logic [1:0] FlagW;
    logic       CondSample, PCS, NextPC, RegW, MemW, SaveFlags, RestoreFlags;
    logic       PCWrite, RegWrite, MemWrite, CondExHeld;

    // legacy instance: NGROUPS=4, HOLD_MODE=0, FLAGW_GATED=0
    logic [3:0] condL, aluFlagsL, flagsL, flagWL;
    logic       condSampleL, pcsL, nextPcL, regWL, memWL, saveL, restoreL;
    logic       pcWriteL, regWriteL, memWriteL, heldL;

    int passCnt = 0;
    int totalCnt = 0;

    always #5 clk = ~clk;

    condlogic_hold #(.NGROUPS(2), .HOLD_MODE(1), .FLAGW_GATED(1)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .CondSample(CondSample), .PCS(PCS), .NextPC(NextPC),
        .RegW(RegW), .MemW(MemW), .SaveFlags(SaveFlags),
        .RestoreFlags(RestoreFlags), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .Flags(Flags), .CondExHeld(CondExHeld)
    );

    condlogic_hold #(.NGROUPS(4), .HOLD_MODE(0), .FLAGW_GATED(0)) dutL (
        .clk(clk), .reset(reset), .Cond(condL), .ALUFlags(aluFlagsL),
        .FlagW(flagWL), .CondSample(condSampleL), .PCS(pcsL), .NextPC(nextPcL),
        .RegW(regWL), .MemW(memWL), .SaveFlags(saveL),
        .RestoreFlags(restoreL), .PCWrite(pcWriteL), .RegWrite(regWriteL),
        .MemWrite(memWriteL), .Flags(flagsL), .CondExHeld(heldL)
    );

    typedef struct {
        logic [3:0] cond;
        logic [3:0] flags;
        logic       exp;
    } condVec_t;

    typedef struct {
        logic held, regW, memW, pcs, nextPc;
        logic eReg, eMem, ePc;
    } gateVec_t;

    condVec_t condVecs[18];
    gateVec_t gateVecs[8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setHeld(input logic v);
        Cond = v ? COND_AL : COND_NV;
        CondSample = 1'b1;
        tick();
        CondSample = 1'b0;
    endtask

    task automatic writeFlags(input logic [3:0] f);
        setHeld(1'b1);
        FlagW = 2'b11;
        ALUFlags = f;
        tick();
        FlagW = 2'b00;
    endtask

    // Independent reference: ARM pairs codes, odd code is the inverse.
    function automatic logic refCond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n ~^ v);
            3'd6: base = !z && (n ~^ v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    initial begin
        logic prevZ, z;

        condVecs[0]  = '{COND_EQ, 4'b0100, 1'b1};
        condVecs[1]  = '{COND_NE, 4'b0100, 1'b0};
        condVecs[2]  = '{COND_CS, 4'b0010, 1'b1};
        condVecs[3]  = '{COND_CC, 4'b0010, 1'b0};
        condVecs[4]  = '{COND_MI, 4'b1000, 1'b1};
        condVecs[5]  = '{COND_PL, 4'b1000, 1'b0};
        condVecs[6]  = '{COND_VS, 4'b0001, 1'b1};
        condVecs[7]  = '{COND_VC, 4'b0000, 1'b1};
        condVecs[8]  = '{COND_HI, 4'b0010, 1'b1};
        condVecs[9]  = '{COND_HI, 4'b0110, 1'b0};
        condVecs[10] = '{COND_LS, 4'b0110, 1'b1};
        condVecs[11] = '{COND_GE, 4'b1001, 1'b1};
        condVecs[12] = '{COND_LT, 4'b1000, 1'b1};
        condVecs[13] = '{COND_GT, 4'b0000, 1'b1};
        condVecs[14] = '{COND_GT, 4'b0100, 1'b0};
        condVecs[15] = '{COND_LE, 4'b0001, 1'b1};
        condVecs[16] = '{COND_AL, 4'b0000, 1'b1};
        condVecs[17] = '{COND_NV, 4'b1111, 1'b0};

        gateVecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        gateVecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        gateVecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        gateVecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        gateVecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        gateVecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        gateVecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        gateVecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // ---- reset and defaults ----
        reset = 1'b0;
        Cond = COND_AL; ALUFlags = 4'h0; FlagW = 2'b00; CondSample = 1'b1;
        PCS = 1'b1; NextPC = 1'b0; RegW = 1'b1; MemW = 1'b1;
        SaveFlags = 1'b0; RestoreFlags = 1'b0;
        condL = COND_AL; aluFlagsL = 4'h0; flagWL = 4'h0; condSampleL = 1'b0;
        pcsL = 1'b0; nextPcL = 1'b0; regWL = 1'b0; memWL = 1'b0;
        saveL = 1'b0; restoreL = 1'b0;
        tick(); tick();
        check("rst_regwrite", {7'd0, RegWrite}, 8'd0);
        check("rst_memwrite", {7'd0, MemWrite}, 8'd0);
        check("rst_pcwrite", {7'd0, PCWrite}, 8'd0);
        check("rst_flags", {4'd0, Flags}, 8'h00);
        check("rst_held", {7'd0, CondExHeld}, 8'd0);
        check("rst_heldL", {7'd0, heldL}, 8'd0);
        reset = 1'b1; NextPC = 1'b1; CondSample = 1'b0;
        #1;
        check("post_rst_pcwrite", {7'd0, PCWrite}, 8'd1);
        PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;

        // ---- hold mode latch and gating ----
        writeFlags(4'b0100);
        check("flags_0100", {4'd0, Flags}, 8'h04);
        Cond = COND_EQ; CondSample = 1'b1;
        tick();
        CondSample = 1'b0;
        check("eq_sample", {7'd0, CondExHeld}, 8'd1);
        FlagW = 2'b11; ALUFlags = 4'b0000;
        tick();
        FlagW = 2'b00;
        check("flags_clr", {4'd0, Flags}, 8'h00);
        check("held_stable", {7'd0, CondExHeld}, 8'd1);
        for (int i = 0; i < 3; i++) begin
            RegW = ~i[0];
            tick();
            check("held_multi", {7'd0, CondExHeld}, 8'd1);
            check("regw_follow", {7'd0, RegWrite}, {7'd0, ~i[0]});
        end
        RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
        Cond = COND_EQ; CondSample = 1'b1;
        tick();
        CondSample = 1'b0;
        check("eq_resample", {7'd0, CondExHeld}, 8'd0);
        check("regw_blocked", {7'd0, RegWrite}, 8'd0);
        check("memw_blocked", {7'd0, MemWrite}, 8'd0);
        check("pcw_blocked", {7'd0, PCWrite}, 8'd0);

        // ---- output gating table ----
        for (int i = 0; i < 8; i++) begin
            RegW = 1'b0; MemW = 1'b0; PCS = 1'b0; NextPC = 1'b0;
            setHeld(gateVecs[i].held);
            RegW = gateVecs[i].regW; MemW = gateVecs[i].memW;
            PCS = gateVecs[i].pcs; NextPC = gateVecs[i].nextPc;
            #1;
            check("gate_reg", {7'd0, RegWrite}, {7'd0, gateVecs[i].eReg});
            check("gate_mem", {7'd0, MemWrite}, {7'd0, gateVecs[i].eMem});
            check("gate_pc", {7'd0, PCWrite}, {7'd0, gateVecs[i].ePc});
        end
        RegW = 1'b0; MemW = 1'b0; PCS = 1'b0; NextPC = 1'b0;

        // ---- hand-computed condition table ----
        for (int i = 0; i < 18; i++) begin
            writeFlags(condVecs[i].flags);
            Cond = condVecs[i].cond; CondSample = 1'b1;
            tick();
            CondSample = 1'b0;
            check("cond_table", {7'd0, CondExHeld}, {7'd0, condVecs[i].exp});
        end

        // ---- grouped, gated flag writes ----
        writeFlags(4'b0000);
        FlagW = 2'b01; ALUFlags = 4'b1111;
        tick();
        check("group0_write", {4'd0, Flags}, 8'h03);
        setHeld(1'b0);
        FlagW = 2'b11; ALUFlags = 4'b1100;
        tick();
        FlagW = 2'b00;
        check("gated_block", {4'd0, Flags}, 8'h03);
        setHeld(1'b1);
        Cond = COND_CS; CondSample = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0000;
        tick();
        CondSample = 1'b0; FlagW = 2'b00;
        check("sample_preedge", {7'd0, CondExHeld}, 8'd1);
        check("sample_flagwr", {4'd0, Flags}, 8'h00);

        // ---- shadow save / restore / swap ----
        writeFlags(4'b1010);
        SaveFlags = 1'b1;
        tick();
        SaveFlags = 1'b0;
        writeFlags(4'b0101);
        check("flags_0101", {4'd0, Flags}, 8'h05);
        RestoreFlags = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1111;
        tick();
        RestoreFlags = 1'b0; FlagW = 2'b00;
        check("restore_prio", {4'd0, Flags}, 8'h0A);
        writeFlags(4'b0110);
        SaveFlags = 1'b1; RestoreFlags = 1'b1;
        tick();
        SaveFlags = 1'b0; RestoreFlags = 1'b0;
        check("swap_flags", {4'd0, Flags}, 8'h0A);
        RestoreFlags = 1'b1;
        tick();
        RestoreFlags = 1'b0;
        check("swap_shadow", {4'd0, Flags}, 8'h06);

        // ---- reset mid-instruction ----
        SaveFlags = 1'b1;
        tick();
        SaveFlags = 1'b0;
        setHeld(1'b1);
        RegW = 1'b1;
        reset = 1'b0;
        tick();
        check("midrst_flags", {4'd0, Flags}, 8'h00);
        check("midrst_held", {7'd0, CondExHeld}, 8'd0);
        check("midrst_regw", {7'd0, RegWrite}, 8'd0);
        reset = 1'b1; RegW = 1'b0;
        RestoreFlags = 1'b1;
        tick();
        RestoreFlags = 1'b0;
        check("midrst_shadow", {4'd0, Flags}, 8'h00);

        // ---- legacy instance: per-bit groups, ungated ----
        flagWL = 4'b1000; aluFlagsL = 4'b1111;
        tick();
        check("L_group3", {4'd0, flagsL}, 8'h08);
        flagWL = 4'b0010;
        tick();
        flagWL = 4'b0000;
        check("L_group1", {4'd0, flagsL}, 8'h0A);

        // ---- legacy instance: full 16x16 condition sweep ----
        for (int f = 0; f < 16; f++) begin
            flagWL = 4'hF; aluFlagsL = f[3:0];
            tick();
            flagWL = 4'h0;
            for (int c = 0; c < 16; c++) begin
                condL = c[3:0];
                condSampleL = 1'($urandom_range(0, 1));
                tick();
                check("sweep", {c[3:0], 3'd0, heldL}, {c[3:0], 3'd0, refCond(c[3:0], f[3:0])});
            end
        end

        // ---- legacy instance: NE tracks !Z with one-cycle lag ----
        flagWL = 4'hF; aluFlagsL = 4'h0;
        tick();
        prevZ = 1'b0;
        condL = COND_NE; flagWL = 4'b0100; regWL = 1'b1;
        for (int i = 0; i < 10; i++) begin
            z = ~i[0];
            aluFlagsL = {1'b0, z, 2'b00};
            condSampleL = 1'($urandom_range(0, 1));
            tick();
            check("L_lag_held", {7'd0, heldL}, {7'd0, ~prevZ});
            check("L_lag_flags", {4'd0, flagsL}, {5'd0, z, 2'b00});
            check("L_regwrite", {7'd0, regWriteL}, {7'd0, ~prevZ});
            prevZ = z;
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
